// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/response bundle for the iterative mul/div unit
interface alu_muldiv_seq_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 3
);
   logic                     in_valid;
   logic                     in_ready;
   logic [OPCODE_LENGTH-1:0] Operation;
   logic [DATA_WIDTH-1:0]    SrcA;
   logic [DATA_WIDTH-1:0]    SrcB;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    Result;

   modport master (
      output in_valid, Operation, SrcA, SrcB, flush, out_ready,
      input  in_ready, out_valid, Result
   );

   modport slave (
      input  in_valid, Operation, SrcA, SrcB, flush, out_ready,
      output in_ready, out_valid, Result
   );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - RV32M multiply/divide, one bit per cycle (shift-add / restoring)
module alu_muldiv_seq #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 3
) (
   input logic              clk,
   input logic              rst_n,
   alu_muldiv_seq_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W) + 1;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(0);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(1);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(2);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULHU  = OPCODE_LENGTH'(3);
   localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(4);
   localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = OPCODE_LENGTH'(5);
   localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(6);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t                   state, state_nxt;
   logic [OPCODE_LENGTH-1:0] op;
   logic                     neg;
   logic [W-1:0]             opnd;
   logic [2*W-1:0]           acc;
   logic [CW-1:0]            counter;
   logic [W-1:0]             result;

   logic                     is_div, signed_a, signed_b, sa, sb;
   logic                     div_by_zero, overflow, special, neg_in;
   logic [W-1:0]             mag_a, mag_b, special_res, fix_res;
   logic [W:0]               mul_sum, div_trial;
   logic [2*W-1:0]           mul_step, div_step, prod_signed;

   // Operand decode at accept: magnitudes, result sign and early-out cases
   always_comb begin
      is_div      = bus.Operation[OPCODE_LENGTH-1];
      signed_a    = bus.Operation inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      signed_b    = bus.Operation inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      sa          = signed_a & bus.SrcA[W-1];
      sb          = signed_b & bus.SrcB[W-1];
      mag_a       = sa ? -bus.SrcA : bus.SrcA;
      mag_b       = sb ? -bus.SrcB : bus.SrcB;
      div_by_zero = is_div && (bus.SrcB == '0);
      overflow    = (bus.Operation == OP_DIV || bus.Operation == OP_REM) &&
                    (bus.SrcA == MIN_NEG) && (&bus.SrcB);
      special     = div_by_zero || overflow;
      if (div_by_zero)
         special_res = bus.Operation[1] ? bus.SrcA : '1;
      else
         special_res = bus.Operation[1] ? '0 : MIN_NEG;
      case (bus.Operation)
         OP_MUL, OP_MULH, OP_DIV: neg_in = sa ^ sb;
         OP_MULHSU, OP_REM:       neg_in = sa;
         default:                 neg_in = 1'b0;
      endcase
   end

   // acc = {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_step    = {mul_sum, acc[W-1:1]};
      div_trial   = {acc[2*W-1:W], acc[W-1]} - {1'b0, opnd};
      div_step    = div_trial[W] ? {acc[2*W-2:W], acc[W-1], acc[W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc[W-2:0], 1'b1};
      prod_signed = neg ? -acc : acc;
      case (op)
         OP_MUL:                      fix_res = prod_signed[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_signed[2*W-1:W];
         OP_DIV, OP_DIVU:             fix_res = neg ? -acc[W-1:0] : acc[W-1:0];
         default:                     fix_res = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) state_nxt = special ? DONE : CALC;
            CALC: if (counter == CW'(W-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op      <= '0;
         neg     <= 1'b0;
         opnd    <= '0;
         acc     <= '0;
         counter <= '0;
         result  <= '0;
      end else if (!bus.flush) begin
         if (state == IDLE && bus.in_valid) begin
            op      <= bus.Operation;
            neg     <= neg_in;
            opnd    <= is_div ? mag_b : mag_a;
            acc     <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
            counter <= '0;
            if (special)
               result <= special_res;
         end else if (state == CALC) begin
            acc     <= op[OPCODE_LENGTH-1] ? div_step : mul_step;
            counter <= counter + 1'b1;
         end else if (state == FIX) begin
            result  <= fix_res;
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.Result    = result;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - randomized bench for alu_muldiv_seq against an arithmetic model
module tb_alu_muldiv_seq;
   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   alu_muldiv_seq_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) bus ();

   alu_muldiv_seq #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic        armed  = 1'b0;
   logic [31:0] exp_res = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub, p;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Any visible result must be the one the model predicts for the accepted request
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         checks++;
         if (!armed) begin
            errors++;
            $display("FAIL unexpected_out_valid got 1 want 0");
         end else if (bus.Result !== exp_res) begin
            errors++;
            $display("FAIL result got %h want %h", bus.Result, exp_res);
         end
      end
   end

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      int   n;
      logic special;
      special = op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
      @(negedge clk);
      check("in_ready_before", bus.in_ready, 1);
      bus.Operation = op;
      bus.SrcA      = a;
      bus.SrcB      = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      exp_res       = model(op, a, b);
      armed         = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.Operation = 3'($urandom);
      bus.SrcA      = $urandom;
      bus.SrcB      = $urandom;
      n = 0;
      while (!bus.out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, special ? 0 : W + 1);
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            check("bp_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
         end
         bus.out_ready = 1'b1;
      end
      @(negedge clk);
      check("drain_valid", bus.out_valid, 0);
      check("drain_in_ready", bus.in_ready, 1);
      armed         = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int flush_ok;
      bus.in_valid  = 1'b0;
      bus.Operation = '0;
      bus.SrcA      = '0;
      bus.SrcB      = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      check("pin_mul",    model(3'd0, 32'd7, 32'hFFFFFFFD),        32'hFFFFFFEB);
      check("pin_mulh",   model(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
      check("pin_mulhu",  model(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
      check("pin_mulhsu", model(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
      check("pin_div",    model(3'd4, 32'hFFFFFFF9, 32'd2),        32'hFFFFFFFD);
      check("pin_rem",    model(3'd6, 32'hFFFFFFF9, 32'd2),        32'hFFFFFFFF);
      check("pin_divu",   model(3'd5, 32'd100, 32'd7),             32'd14);
      check("pin_remu",   model(3'd7, 32'd100, 32'd7),             32'd2);
      check("pin_rem0",   model(3'd6, 32'd5, 32'd0),               32'd5);
      check("pin_divovf", model(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

      repeat (3) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready",  bus.in_ready, 1);
      check("rst_result",    bus.Result, 0);
      rst_n = 1'b1;

      do_op(3'd0, 32'd7, 32'hFFFFFFFD, 0);
      do_op(3'd1, 32'h80000000, 32'h80000000, 0);
      do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      do_op(3'd4, 32'hFFFFFFF9, 32'd2, 0);
      do_op(3'd6, 32'hFFFFFFF9, 32'd2, 0);
      do_op(3'd5, 32'd100, 32'd7, 0);
      do_op(3'd7, 32'd100, 32'd7, 0);
      do_op(3'd5, 32'hFFFFFFFF, 32'd1, 0);
      do_op(3'd4, 32'd5, 32'd0, 0);
      do_op(3'd6, 32'd5, 32'd0, 0);
      do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
      do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
      do_op(3'd5, 32'd100, 32'd7, 10);

      // Flush ten cycles into CALC while a second request is offered
      @(negedge clk);
      bus.Operation = 3'd5;
      bus.SrcA      = 32'd100;
      bus.SrcB      = 32'd7;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      repeat (10) @(negedge clk);
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.Operation = 3'd0;
      bus.SrcA      = 32'd1;
      bus.SrcB      = 32'd1;
      @(negedge clk);
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      check("flush_in_ready",  bus.in_ready, 1);
      check("flush_out_valid", bus.out_valid, 0);
      flush_ok = 1;
      repeat (40) begin
         @(negedge clk);
         if (!bus.in_ready) flush_ok = 0;
      end
      check("flush_not_accepted", flush_ok, 1);

      // Asynchronous reset mid-CALC
      @(negedge clk);
      bus.Operation = 3'd0;
      bus.SrcA      = 32'd9;
      bus.SrcB      = 32'd9;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      repeat (5) @(negedge clk);
      check("calc_in_ready", bus.in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", bus.out_valid, 0);
      check("async_rst_in_ready",  bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(3'd0, 32'd3, 32'd4, 0);
      check("pin_mul_3x4", model(3'd0, 32'd3, 32'd4), 32'd12);

      for (int i = 0; i < 40; i++)
         do_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative multiply/divide unit implementing the RV32M operations; sits beside the combinational ALU in the execute stage.
- Parametrised in data width.
- Takes one operation at a time over a valid/ready handshake and computes it over multiple cycles (shift-add multiply, restoring divide).
- Holds the result until the consumer accepts it.

Parameters:
- DATA_WIDTH, 32, operand and result width (W); must be even and >= 4.
- OPCODE_LENGTH, 3, operation select width; encoding equals RV32M funct3.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high exactly when state is IDLE.
- Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  DATA_WIDTH  operand A (multiplicand/dividend).
- SrcB  input  DATA_WIDTH  operand B (multiplier/divisor).
- flush  input  1  abort any in-flight operation.
- out_valid  output  1  Result valid.
- out_ready  input  1  consumer accepts Result.
- Result  output  DATA_WIDTH  operation result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, out_valid=0, Result=0, counter=0, internal registers=0.
  - in_ready=1 follows from state IDLE.
  - Reset mid-operation discards the operation with no output.
- States: IDLE, CALC, FIX, DONE.
- Accept: in_valid && in_ready at a rising edge.
  - Latch Operation, sign flags, and operand magnitudes.
  - Signed interpretation applies to A for MUL/MULH/MULHSU/DIV/REM, and to B for MUL/MULH/DIV/REM.
- Special cases, decided at accept (IDLE -> DONE, Result valid 1 edge after accept):
  - DIV/DIVU with B=0 -> all ones.
  - REM/REMU with B=0 -> A.
  - DIV with A=most-negative and B=-1 -> most-negative.
  - REM with A=most-negative and B=-1 -> 0.
- Normal path: IDLE -> CALC, counter=0.
  - Each CALC edge processes one bit; counter increments.
  - After W CALC edges: CALC -> FIX.
  - FIX edge: apply sign correction, register Result -> DONE.
  - out_valid rises W+1 edges after the accept edge (33 for W=32).
- Multiply:
  - Unsigned 2W-bit shift-add of the magnitudes.
  - Product negated when its sign flag is set: sA^sB for MUL/MULH, sA for MULHSU, never for MULHU.
  - MUL returns the low W bits; the MULH variants return the high W bits.
- Divide:
  - Restoring division on the magnitudes, one quotient bit per cycle, MSB first.
  - Quotient negated if sA^sB (DIV only).
  - Remainder negated if sA (REM only).
  - Remainder sign always equals dividend sign.
- DONE:
  - out_valid=1; Result held stable until out_ready.
  - out_valid && out_ready at an edge -> IDLE, out_valid=0.
  - in_ready is 0 in DONE, so there is no same-cycle accept; the next accept is possible one cycle after the drain.
- Flush:
  - From any state, next edge -> IDLE with out_valid=0; the Result value is don't-care.
  - Flush has priority over in_valid, out_ready, and the CALC progress.
- Input stability:
  - Operand/Operation inputs are ignored outside the accept edge.
  - Changing them mid-operation has no effect.
- All arithmetic is modulo 2^W on Result; intermediate product registers are 2W bits; counter width is $clog2(W)+1.

Test Plan:
1. MUL 7 * 0xFFFFFFFD (-3), out_ready=1 -> Result 0xFFFFFFEB; out_valid high exactly on cycle 33 after accept, for one cycle; in_ready high the next cycle.
2. High products -> MULH 0x80000000*0x80000000 = 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFF.
3. Division -> DIV 0xFFFFFFF9/2 = 0xFFFFFFFD; REM 0xFFFFFFF9/2 = 0xFFFFFFFF; DIVU 100/7 = 14; REMU 100/7 = 2; DIVU 0xFFFFFFFF/1 = 0xFFFFFFFF.
4. Special cases -> DIV 5/0 = 0xFFFFFFFF; REM 5/0 = 5; DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM of the same = 0; each with out_valid one edge after accept.
5. Backpressure: DIVU 100/7 with out_ready=0 for 10 cycles after out_valid -> out_valid and Result=14 stable throughout, in_ready=0; drain on out_ready=1, then IDLE.
6. Flush and reset:
   - flush at CALC counter=10, with in_valid=1 on the same cycle -> IDLE next edge, no out_valid, that request not accepted.
   - rst_n low mid-CALC -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
   - The subsequent MUL 3*4 -> 12.
